// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions: default Q(N.M) format, divider FSM states
// and the width helper used by the divider and the multiplier.
package fixed_point_pkg;

  localparam int DEFAULT_N = 5;
  localparam int DEFAULT_M = 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  function automatic int fixed_width(input int n, input int m);
    return n + m;
  endfunction

endpackage

// File: rtl/fixed_div_step.sv
// One combinational restoring-division step: shift in a numerator bit,
// trial-subtract the divisor, keep the difference or restore.
module fixed_div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem,
  input  logic         num_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   new_rem,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // The remainder stays below the divisor, so the top bit of diff is a valid sign.
  always_comb begin
    shifted = {rem, num_bit};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[W+1];
    new_rem = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/fixed_point_division.sv
// Sequential unsigned Q(N.M) restoring divider, one quotient bit per clock.
// Define FIXED_DIV_ROUNDING_EN for round-half-up; otherwise the quotient truncates.
module fixed_point_division
  import fixed_point_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int M = DEFAULT_M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N+M-1:0]   x,
  input  logic [N+M-1:0]   y,
  output logic             ready,
  output logic             done,
  output logic [N+M-1:0]   result,
  output logic             ovf,
  output logic             dbz
);

  localparam int W  = fixed_width(N, M);
  localparam int QW = W + M;
  localparam int CW = $clog2(QW + 1);

  div_state_t    state, next_state;
  logic [QW-1:0] num;
  logic [QW-1:0] quo;
  logic [W-1:0]  div;
  logic [W:0]    rem;
  logic [CW-1:0] count;
  logic          last_step;
  logic [W:0]    step_rem;
  logic          step_q;
  logic [QW:0]   q_final;
  logic          q_over;

  fixed_div_step #(.W(W)) u_step (
    .rem     (rem),
    .num_bit (num[QW-1]),
    .divisor (div),
    .new_rem (step_rem),
    .q_bit   (step_q)
  );

  assign last_step = (count == CW'(QW - 1));

`ifdef FIXED_DIV_ROUNDING_EN
  logic round_up;
  // Half-up: compare twice the final remainder with the divisor.
  assign round_up = ({step_rem, 1'b0} >= {2'b00, div});
  assign q_final  = {1'b0, quo[QW-2:0], step_q} + (QW+1)'(round_up);
`else
  assign q_final  = {1'b0, quo[QW-2:0], step_q};
`endif

  assign q_over = |q_final[QW:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (y == '0) ? DONE : CALC;
      CALC:    if (last_step) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Datapath: operands latch on accept, results register on the edge into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num    <= '0;
      quo    <= '0;
      div    <= '0;
      rem    <= '0;
      count  <= '0;
      result <= '0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num   <= QW'(x) << M;
            div   <= y;
            rem   <= '0;
            quo   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            if (y == '0) begin
              result <= '1;
              dbz    <= 1'b1;
            end else begin
              result <= '0;
              dbz    <= 1'b0;
            end
          end
        end
        CALC: begin
          num   <= num << 1;
          rem   <= step_rem;
          quo   <= {quo[QW-2:0], step_q};
          count <= count + 1'b1;
          if (last_step) begin
            count <= '0;
            if (q_over) begin
              result <= '1;
              ovf    <= 1'b1;
            end else begin
              result <= q_final[W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_division.sv
// Self-checking bench for fixed_point_division: directed cases from the
// divider's examples plus random operands against an arithmetic reference.
module tb_fixed_point_division;

  localparam int N = 5;
  localparam int M = 3;
  localparam int W = N + M;
  localparam int LAT = W + M;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;
  logic         dbz;

  int tests;
  int failed;

  fixed_point_division #(.N(N), .M(M)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .y      (y),
    .ready  (ready),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .dbz    (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Quotient of (x * 2^M) / y in plain integer arithmetic.
  task automatic refModel(input logic [W-1:0] xi, input logic [W-1:0] yi,
                          output logic [W-1:0] r, output logic o, output logic d);
    longint num, q, rm;
    if (yi == '0) begin
      r = '1; o = 1'b0; d = 1'b1;
    end else begin
      num = longint'(xi) * (longint'(1) << M);
      q   = num / longint'(yi);
      rm  = num % longint'(yi);
`ifdef FIXED_DIV_ROUNDING_EN
      if (2 * rm >= longint'(yi)) q = q + 1;
`endif
      d = 1'b0;
      if (q >= (longint'(1) << W)) begin
        r = '1; o = 1'b1;
      end else begin
        r = W'(q); o = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] xi, input logic [W-1:0] yi, input bit poke,
                               output int lat, output logic [W-1:0] r, output logic o,
                               output logic d, output bit busy_ok, output bit pulse_ok);
    int waited;
    busy_ok = 1'b1;
    waited  = 0;
    while (!ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ready) busy_ok = 1'b0;
    @(negedge clk);
    x = xi; y = yi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 0; c <= 40; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (ready) busy_ok = 1'b0;
      if (poke && (c == 3 || c == 7)) begin
        x = 8'hA5 ^ W'(c); y = 8'h03; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    r = result; o = ovf; d = dbz;
    @(posedge clk); #1;
    pulse_ok = !done && ready;
  endtask

  task automatic runAndCheck(input string tag, input logic [W-1:0] xi, input logic [W-1:0] yi, input bit poke);
    int lat;
    logic [W-1:0] r, er;
    logic o, d, eo, ed;
    bit busy_ok, pulse_ok;
    applyStimulus(xi, yi, poke, lat, r, o, d, busy_ok, pulse_ok);
    refModel(xi, yi, er, eo, ed);
    checkOutput({tag, "_result"}, 32'(r), 32'(er));
    checkOutput({tag, "_ovf"}, 32'(o), 32'(eo));
    checkOutput({tag, "_dbz"}, 32'(d), 32'(ed));
    checkOutput({tag, "_latency"}, 32'(lat), (yi == '0) ? 32'd0 : 32'(LAT));
    checkOutput({tag, "_busy"}, 32'(busy_ok), 32'd1);
    checkOutput({tag, "_pulse"}, 32'(pulse_ok), 32'd1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] r;
    logic o, d;
    bit busy_ok, pulse_ok;
    logic [W-1:0] rx, ry;

    tests = 0; failed = 0;
    rst_n = 1'b1; start = 1'b0; x = '0; y = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_flags", {29'd0, ovf, dbz, done}, 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 14.0 / 2.25 with spec-listed expected quotient
    applyStimulus(8'b01110000, 8'b00010010, 1'b0, lat, r, o, d, busy_ok, pulse_ok);
`ifdef FIXED_DIV_ROUNDING_EN
    checkOutput("div14_result", 32'(r), 32'b00110010);
`else
    checkOutput("div14_result", 32'(r), 32'b00110001);
`endif
    checkOutput("div14_flags", {30'd0, o, d}, 32'd0);
    checkOutput("div14_latency", 32'(lat), 32'd11);
    checkOutput("div14_pulse", 32'(pulse_ok), 32'd1);

    applyStimulus(8'b00001100, 8'b00000110, 1'b0, lat, r, o, d, busy_ok, pulse_ok);
    checkOutput("div1p5_result", 32'(r), 32'b00010000);
    checkOutput("div1p5_flags", {30'd0, o, d}, 32'd0);

    runAndCheck("overflow", 8'hFF, 8'h01, 1'b0);
    runAndCheck("divzero", 8'b00101000, 8'h00, 1'b0);
    runAndCheck("busy_poke", 8'b01110000, 8'b00010010, 1'b1);

    // Reset in the middle of CALC
    @(negedge clk);
    x = 8'b01110000; y = 8'b00010010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_result", 32'(result), 32'd0);
    checkOutput("midreset_flags", {29'd0, ovf, dbz, done}, 32'd0);
    checkOutput("midreset_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    runAndCheck("after_reset", 8'b00001100, 8'b00000110, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rx = W'($urandom);
      case ($urandom_range(0, 3))
        0:       ry = '0;
        1:       ry = W'($urandom_range(1, 7));
        default: ry = W'($urandom);
      endcase
      runAndCheck("random", rx, ry, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
